// File: rtl/instr_mem_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the instruction fetch memory: instruction field bit
// positions, the NOP word returned on a faulting fetch, and the loader FSM
// state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package instr_mem_pkg;

    // Instruction field positions inside a 32-bit word
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int JMP_HI = 25;
    localparam int JMP_LO = 0;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS_HI  = 20;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 11;
    localparam int IMM_HI = 10;
    localparam int IMM_LO = 0;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

endpackage

// File: rtl/instr_fetch_mem_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_mem_if
// Groups the fetch, relocation-base and burst-loader signals of the
// instruction memory.
//   master : PC/control unit + HD/OS loader side (drives pc, fetch_en,
//            exec_mode, base_we/base_in, load_* and bios_wr_en)
//   slave  : the instruction memory (drives load_ready/done/error,
//            fetch_valid/fault and the decoded fields)
// -----------------------------------------------------------------------------
interface instr_fetch_mem_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              exec_mode;
    logic              base_we;
    logic [ADDR_W-1:0] base_in;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [15:0]       load_count;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              bios_wr_en;

    logic              load_ready;
    logic              load_done;
    logic              load_error;
    logic              fetch_valid;
    logic              fetch_fault;
    logic [5:0]        opcode;
    logic [25:0]       jump;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [15:0]       imediato;

    modport master (
        output pc, fetch_en, exec_mode, base_we, base_in,
               load_start, load_base, load_count, load_valid, load_data, bios_wr_en,
        input  load_ready, load_done, load_error, fetch_valid, fetch_fault,
               opcode, jump, rd, rs, rt, imediato
    );

    modport slave (
        input  pc, fetch_en, exec_mode, base_we, base_in,
               load_start, load_base, load_count, load_valid, load_data, bios_wr_en,
        output load_ready, load_done, load_error, fetch_valid, fetch_fault,
               opcode, jump, rd, rs, rt, imediato
    );
endinterface

// File: rtl/instr_mem_ram.sv
// -----------------------------------------------------------------------------
// instr_mem_ram
// Synchronous 32-bit RAM, one write port and one read port. The read data is
// registered and only updated when re_i is high, so it holds during stalls.
// A read of the address being written in the same cycle returns the new word.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write word address
//   wdata_i  write data
//   re_i     read enable (updates rdata_o at the edge)
//   raddr_i  read word address
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module instr_mem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            // Write-first: forward the word being written to a same-address read
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// instr_fetch_mem
// Instruction memory with a burst loader and base-relocated fetch.
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous, active-high
//   bus    instr_fetch_mem_if.slave:
//            fetch side : pc, fetch_en, exec_mode, base_we, base_in ->
//                         fetch_valid, fetch_fault, opcode, jump, rd, rs, rt,
//                         imediato (registered, one cycle after pc)
//            loader side: load_start, load_base, load_count, load_valid,
//                         load_data, bios_wr_en -> load_ready, load_done,
//                         load_error
// -----------------------------------------------------------------------------
module instr_fetch_mem
    import instr_mem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 32,
    parameter int BIOS_DEPTH = 128
) (
    input  logic               clock,
    input  logic               reset,
    instr_fetch_mem_if.slave   bus
);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BIOS_A  = ADDR_W'(BIOS_DEPTH);

    // Loader state
    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       remaining_q, remaining_d;
    logic              load_error_q, load_error_d;

    // Fetch state
    logic [ADDR_W-1:0] user_base_q;
    logic              fetch_valid_q;
    logic              fetch_fault_q;
    logic              nop_q;          // outputs forced to NOP (after reset or fault)

    logic              accept;
    logic              wr_legal;
    logic              ram_we;
    logic [ADDR_W-1:0] phys;
    logic              fault;
    logic              ram_re;
    logic [31:0]       ram_rdata;
    logic [31:0]       word;

    // ---------------------------------------------------------------- loader
    assign accept   = (state_q == LD_LOAD) && bus.load_valid;
    assign wr_legal = (wr_addr_q < DEPTH_A) && ((wr_addr_q >= BIOS_A) || bus.bios_wr_en);
    // A burst aborted by reset must not commit the word presented that cycle
    assign ram_we   = accept && wr_legal && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LD_IDLE;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_error_q <= load_error_d;
        end
    end

    always_ff @(posedge clock) begin
        wr_addr_q   <= wr_addr_d;
        remaining_q <= remaining_d;
    end

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        remaining_d  = remaining_q;
        load_error_d = load_error_q;
        unique case (state_q)
            LD_IDLE: begin
                if (bus.load_start) begin
                    wr_addr_d    = bus.load_base;
                    remaining_d  = bus.load_count;
                    load_error_d = 1'b0;
                    state_d      = (bus.load_count == 16'd0) ? LD_DONE : LD_LOAD;
                end
            end
            LD_LOAD: begin
                // Address and count advance even for dropped words
                if (accept) begin
                    wr_addr_d   = wr_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - 16'd1;
                    if (!wr_legal) begin
                        load_error_d = 1'b1;
                    end
                    if (remaining_q == 16'd1) begin
                        state_d = LD_DONE;
                    end
                end
            end
            LD_DONE: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    assign bus.load_ready = (state_q == LD_LOAD);
    assign bus.load_done  = (state_q == LD_DONE);
    assign bus.load_error = load_error_q;

    // ---------------------------------------------------------------- fetch
    assign phys   = bus.exec_mode ? (user_base_q + bus.pc) : bus.pc;
    assign fault  = (phys >= DEPTH_A) || (bus.exec_mode && (phys < BIOS_A));
    assign ram_re = bus.fetch_en && !fault && !reset;

    instr_mem_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .waddr_i (wr_addr_q[RAM_AW-1:0]),
        .wdata_i (bus.load_data),
        .re_i    (ram_re),
        .raddr_i (phys[RAM_AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            user_base_q   <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            nop_q         <= 1'b1;
        end else begin
            if (bus.base_we) begin
                user_base_q <= bus.base_in;
            end
            if (bus.fetch_en) begin
                // Code is never issued while a burst is in flight
                fetch_valid_q <= !fault && (state_q == LD_IDLE);
                fetch_fault_q <= fault;
                nop_q         <= fault;
            end
        end
    end

    // ---------------------------------------------------------------- decode
    assign word = nop_q ? NOP_WORD : ram_rdata;

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.opcode      = word[OP_HI:OP_LO];
    assign bus.jump        = word[JMP_HI:JMP_LO];
    assign bus.rd          = word[RD_HI:RD_LO];
    assign bus.rs          = word[RS_HI:RS_LO];
    assign bus.rt          = word[RT_HI:RT_LO];
    assign bus.imediato    = {5'b0, word[IMM_HI:IMM_LO]};
endmodule

// File: tb/tb_instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_mem
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model of the loader and fetch path.
// -----------------------------------------------------------------------------
module tb_instr_fetch_mem;
    localparam int DEPTH      = 256;
    localparam int ADDR_W     = 32;
    localparam int BIOS_DEPTH = 128;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    instr_fetch_mem_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_mem #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .BIOS_DEPTH (BIOS_DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_loading, m_done, m_err;
    logic [31:0] m_addr;
    int          m_left;
    logic [31:0] m_ubase;
    bit          m_valid, m_fault, m_word_known;
    logic [31:0] m_word;

    function automatic bit legal_wr(input logic [31:0] a, input bit bios_ok);
        return (a < DEPTH) && ((a >= BIOS_DEPTH) || bios_ok);
    endfunction

    task automatic model_step();
        logic [31:0] phys;
        bit          busy, flt, wr_now;
        if (reset) begin
            m_loading = 0; m_done = 0; m_err = 0; m_ubase = 0;
            m_valid = 0; m_fault = 0; m_word = 0; m_word_known = 1;
            return;
        end
        busy   = m_loading || m_done;
        wr_now = m_loading && bus.load_valid && legal_wr(m_addr, bus.bios_wr_en);
        if (bus.fetch_en) begin
            phys = bus.exec_mode ? (m_ubase + bus.pc) : bus.pc;
            flt  = (phys >= DEPTH) || (bus.exec_mode && (phys < BIOS_DEPTH));
            if (flt) begin
                m_fault = 1; m_valid = 0; m_word = 0; m_word_known = 1;
            end else begin
                m_fault = 0;
                m_valid = !busy;
                if (wr_now && (m_addr == phys)) begin
                    m_word = bus.load_data; m_word_known = 1;
                end else begin
                    m_word = m_mem[phys[7:0]]; m_word_known = m_known[phys[7:0]];
                end
            end
        end
        if (bus.base_we) m_ubase = bus.base_in;
        if (m_done) begin
            m_done = 0;
        end else if (m_loading) begin
            if (bus.load_valid) begin
                if (wr_now) begin
                    m_mem[m_addr[7:0]]   = bus.load_data;
                    m_known[m_addr[7:0]] = 1;
                end else begin
                    m_err = 1;
                end
                m_addr = m_addr + 1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_loading = 0; m_done = 1;
                end
            end
        end else if (bus.load_start) begin
            m_err  = 0;
            m_addr = bus.load_base;
            m_left = int'(bus.load_count);
            if (m_left == 0) m_done = 1;
            else             m_loading = 1;
        end
    endtask

    task automatic compare_all();
        chk("load_ready",  32'(bus.load_ready),  32'(m_loading));
        chk("load_done",   32'(bus.load_done),   32'(m_done));
        chk("load_error",  32'(bus.load_error),  32'(m_err));
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_valid));
        chk("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
        if (m_word_known) begin
            chk("opcode",   32'(bus.opcode),   32'(m_word[31:26]));
            chk("jump",     32'(bus.jump),     32'(m_word[25:0]));
            chk("rd",       32'(bus.rd),       32'(m_word[25:21]));
            chk("rs",       32'(bus.rs),       32'(m_word[20:16]));
            chk("rt",       32'(bus.rt),       32'(m_word[15:11]));
            chk("imediato", 32'(bus.imediato), {21'b0, m_word[10:0]});
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        reset = 0;
        bus.pc = '0; bus.fetch_en = 0; bus.exec_mode = 0;
        bus.base_we = 0; bus.base_in = '0;
        bus.load_start = 0; bus.load_base = '0; bus.load_count = '0;
        bus.load_valid = 0; bus.load_data = '0; bus.bios_wr_en = 0;
    endtask

    task automatic start_burst(input logic [31:0] base, input logic [15:0] cnt, input bit bios_ok);
        bus.load_start = 1; bus.load_base = base; bus.load_count = cnt; bus.bios_wr_en = bios_ok;
        cyc();
        bus.load_start = 0;
    endtask

    task automatic fetch(input logic [31:0] p, input bit mode);
        bus.fetch_en = 1; bus.pc = p; bus.exec_mode = mode;
        cyc();
        bus.fetch_en = 0;
    endtask

    logic [31:0] tp_words [4];
    logic [15:0] frozen_q [4];

    initial begin
        tp_words[0] = 32'h6880_0004; tp_words[1] = 32'h6800_0001;
        tp_words[2] = 32'h6820_0001; tp_words[3] = 32'h6461_0000;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        m_loading = 0; m_done = 0; m_err = 0; m_ubase = 0; m_addr = 0; m_left = 0;
        m_valid = 0; m_fault = 0; m_word = 0; m_word_known = 1;

        // Reset
        idle_inputs();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        cyc();
        chk("rst_opcode", 32'(bus.opcode), 32'd0);

        // Burst load at 130
        start_burst(32'd130, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.load_valid = 1; bus.load_data = tp_words[i];
            cyc();
        end
        bus.load_valid = 0;
        chk("burst_done_pulse", 32'(bus.load_done), 32'd1);
        cyc();

        // User-mode fetch with base 130
        bus.base_we = 1; bus.base_in = 32'd130;
        cyc();
        bus.base_we = 0;
        fetch(32'd0, 1'b1);
        chk("tp_op0",  32'(bus.opcode),   32'b011010);
        chk("tp_imm0", 32'(bus.imediato), 32'd4);
        fetch(32'd3, 1'b1);
        chk("tp_op3", 32'(bus.opcode), 32'b011001);
        chk("tp_rd3", 32'(bus.rd),     32'd3);
        chk("tp_rs3", 32'(bus.rs),     32'd1);

        // Relocation sum wraps at ADDR_W
        bus.base_we = 1; bus.base_in = 32'hFFFF_FFFF;
        cyc();
        bus.base_we = 0;
        fetch(32'd131, 1'b1);

        // BIOS protection, with a stray load_start mid-burst
        start_burst(32'd10, 16'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1; bus.load_data = $urandom; bus.load_start = (i == 1);
            cyc();
        end
        bus.load_valid = 0; bus.load_start = 0;
        cyc();
        chk("bios_err_set", 32'(bus.load_error), 32'd1);
        start_burst(32'd10, 16'd3, 1'b1);
        chk("bios_err_clr", 32'(bus.load_error), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1; bus.load_data = $urandom;
            cyc();
        end
        bus.load_valid = 0;
        cyc();
        for (int i = 0; i < 3; i++) fetch(32'(10 + i), 1'b0);

        // Zero-length burst
        start_burst(32'd200, 16'd0, 1'b0);
        cyc();

        // Faults
        bus.base_we = 1; bus.base_in = 32'd0;
        cyc();
        bus.base_we = 0;
        fetch(32'd5, 1'b1);
        chk("flt_user", 32'(bus.fetch_fault), 32'd1);
        chk("flt_jump", 32'(bus.jump),        32'd0);
        fetch(32'(DEPTH), 1'b0);
        chk("flt_depth", 32'(bus.fetch_fault), 32'd1);
        fetch(32'(DEPTH - 1), 1'b0);

        // Stall
        fetch(32'd133, 1'b0);
        frozen_q[0] = 16'(bus.opcode); frozen_q[1] = 16'(bus.imediato);
        for (int i = 0; i < 3; i++) begin
            bus.fetch_en = 0; bus.pc = $urandom_range(0, DEPTH + 4); bus.exec_mode = 1'($urandom_range(0, 1));
            cyc();
            chk("stall_op",  32'(bus.opcode),   32'(frozen_q[0]));
            chk("stall_imm", 32'(bus.imediato), 32'(frozen_q[1]));
        end

        // Write/fetch collision at 140
        start_burst(32'd140, 16'd1, 1'b0);
        bus.load_valid = 1; bus.load_data = 32'hFFFF_FFFF;
        bus.fetch_en = 1; bus.pc = 32'd140; bus.exec_mode = 0;
        cyc();
        bus.load_valid = 0; bus.fetch_en = 0;
        chk("coll_op", 32'(bus.opcode), 32'h3F);
        cyc();

        // Reset mid-burst after 2 of 5 words
        start_burst(32'd150, 16'd5, 1'b0);
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1; bus.load_data = $urandom;
            cyc();
        end
        reset = 1;
        cyc();
        reset = 0; bus.load_valid = 0;
        cyc();
        chk("abort_done", 32'(bus.load_done), 32'd0);
        fetch(32'd150, 1'b0);
        fetch(32'd151, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 149) == 0);
            bus.load_start = ($urandom_range(0, 7) == 0);
            bus.load_base  = $urandom_range(0, DEPTH + 8);
            bus.load_count = 16'($urandom_range(0, 6));
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_data  = $urandom;
            bus.bios_wr_en = 1'($urandom_range(0, 1));
            bus.fetch_en   = ($urandom_range(0, 3) != 0);
            bus.exec_mode  = 1'($urandom_range(0, 1));
            bus.pc         = $urandom_range(0, DEPTH + 4);
            bus.base_we    = ($urandom_range(0, 19) == 0);
            bus.base_in    = $urandom_range(0, 160);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
